// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style accumulator CPU core.
// Executes one instruction per enabled clock from an asynchronous-read program ROM.
module td4x_core #(
  parameter int          DATA_W   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step_en,
  output logic [DATA_W-1:0] instr_addr,
  input  logic [DATA_W+3:0] instr_data,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] LED,
  output logic              carry,
  output logic              halted
);

  localparam logic [DATA_W-1:0] PC_INIT = DATA_W'(RESET_PC);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic              carry_q, carry_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] pc_inc;
  logic [DATA_W:0]   sum_a;
  logic [DATA_W:0]   sum_b;

  assign op     = instr_data[DATA_W+3:DATA_W];
  assign im     = instr_data[DATA_W-1:0];
  assign pc_inc = pc_q + DATA_W'(1);
  assign sum_a  = {1'b0, a_q} + {1'b0, im};
  assign sum_b  = {1'b0, b_q} + {1'b0, im};

  // Next-state decode: every executed instruction clears carry unless it is an ADD.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    pc_d     = pc_q;
    led_d    = led_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    if (step_en && (state_q == ST_RUN)) begin
      pc_d    = pc_inc;
      carry_d = 1'b0;
      case (op)
        4'b0000: {carry_d, a_d} = sum_a;
        4'b0001: a_d = b_q;
        4'b0010: a_d = sw;
        4'b0011: a_d = im;
        4'b0100: b_d = a_q;
        4'b0101: {carry_d, b_d} = sum_b;
        4'b0110: b_d = sw;
        4'b0111: b_d = im;
        4'b1000: begin
          pc_d     = pc_q;
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
        4'b1001: led_d = b_q;
        4'b1010: led_d = a_q;
        4'b1011: led_d = im;
        4'b1100: pc_d = pc_inc;
        4'b1101: begin
          if (carry_q) pc_d = im;
          else         pc_d = pc_inc;
        end
        4'b1110: begin
          if (!carry_q) pc_d = im;
          else          pc_d = pc_inc;
        end
        4'b1111: pc_d = im;
        default: pc_d = pc_inc;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset that overrides step_en and HALT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      pc_q     <= PC_INIT;
      led_q    <= {DATA_W{1'b0}};
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      pc_q     <= pc_d;
      led_q    <= led_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
    end
  end

  assign instr_addr = pc_q;
  assign LED        = led_q;
  assign carry      = carry_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_td4x_core.sv
// Directed self-checking bench for td4x_core: a 4-bit and an 8-bit instance,
// each fed from a bench-side asynchronous ROM.
module tb_td4x_core;

  logic        clock;
  int          checks;
  int          errors;

  // 4-bit instance
  logic        reset4, step4;
  logic [3:0]  addr4, sw4, led4;
  logic [7:0]  instr4;
  logic        carry4, halted4;
  logic [7:0]  rom4 [0:15];

  // 8-bit instance
  logic        reset8, step8;
  logic [7:0]  addr8, sw8, led8;
  logic [11:0] instr8;
  logic        carry8, halted8;
  logic [11:0] rom8 [0:255];

  assign instr4 = rom4[addr4];
  assign instr8 = rom8[addr8];

  td4x_core #(.DATA_W(4), .RESET_PC(0)) u4 (
    .clock(clock), .reset(reset4), .step_en(step4), .instr_addr(addr4),
    .instr_data(instr4), .sw(sw4), .LED(led4), .carry(carry4), .halted(halted4)
  );

  td4x_core #(.DATA_W(8), .RESET_PC(8'h10)) u8 (
    .clock(clock), .reset(reset8), .step_en(step8), .instr_addr(addr8),
    .instr_data(instr8), .sw(sw8), .LED(led8), .carry(carry8), .halted(halted8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill4(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom4[i] = v;
  endtask

  task automatic reset4_pulse();
    reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_led;
    logic [4:0] exp_led;
    int         cyc;

    checks = 0;
    errors = 0;
    reset4 = 1'b1; step4 = 1'b1; sw4 = 4'd0;
    reset8 = 1'b1; step8 = 1'b0; sw8 = 8'd0;
    fill4(8'h3F);
    for (int i = 0; i < 256; i++) rom8[i] = 12'hC00;

    // Reset for two edges with step_en high, then hold with step_en low
    tick();
    tick();
    chk("rst_a", {12'd0, u4.a_q}, 16'h0);
    chk("rst_pc", {12'd0, addr4}, 16'h0);
    chk("rst_led", {12'd0, led4}, 16'h0);
    chk("rst_carry", {15'd0, carry4}, 16'h0);
    chk("rst_halted", {15'd0, halted4}, 16'h0);
    reset4 = 1'b0; step4 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_pc", {12'd0, addr4}, 16'h0);
    chk("hold_a", {12'd0, u4.a_q}, 16'h0);

    // Counter loop: MOV A,1; OUT A; ADD A,1; JNC 1; HALT
    fill4(8'hC0);
    rom4[0] = 8'h31; rom4[1] = 8'hA0; rom4[2] = 8'h01; rom4[3] = 8'hE1; rom4[4] = 8'h80;
    reset4_pulse();
    step4 = 1'b1;
    prev_led = 4'd0;
    exp_led = 5'd1;
    for (cyc = 0; cyc < 100 && !halted4; cyc++) begin
      tick();
      if (led4 !== prev_led) begin
        chk("cnt_led", {12'd0, led4}, {11'd0, exp_led});
        prev_led = led4;
        exp_led = exp_led + 5'd1;
      end
      if (addr4 == 4'd3 && u4.a_q == 4'd0) chk("cnt_wrap_carry", {15'd0, carry4}, 16'h1);
    end
    chk("cnt_no_timeout", {15'd0, (cyc < 100)}, 16'h1);
    chk("cnt_steps", {11'd0, exp_led}, 16'd16);
    chk("cnt_halted", {15'd0, halted4}, 16'h1);
    chk("cnt_led_final", {12'd0, led4}, 16'hF);
    chk("cnt_a_final", {12'd0, u4.a_q}, 16'h0);
    chk("cnt_carry_final", {15'd0, carry4}, 16'h0);
    chk("cnt_pc_final", {12'd0, addr4}, 16'h4);

    // Carry cleared by NOP, so JC 7 falls through
    fill4(8'hC0);
    rom4[0] = 8'h0F; rom4[1] = 8'h01; rom4[2] = 8'hC0; rom4[3] = 8'hD7;
    reset4_pulse();
    tick();
    tick();
    chk("jc_carry_set", {15'd0, carry4}, 16'h1);
    chk("jc_a_wrap", {12'd0, u4.a_q}, 16'h0);
    tick();
    chk("jc_nop_clears", {15'd0, carry4}, 16'h0);
    tick();
    chk("jc_not_taken", {12'd0, addr4}, 16'h4);

    // Without the NOP the JC is taken
    rom4[2] = 8'hD7; rom4[3] = 8'hC0;
    reset4_pulse();
    tick();
    tick();
    tick();
    chk("jc_taken", {12'd0, addr4}, 16'h7);
    chk("jc_clears_carry", {15'd0, carry4}, 16'h0);

    // IN / MOV / OUT with sw = 1010
    fill4(8'hC0);
    rom4[0] = 8'h60; rom4[1] = 8'h10; rom4[2] = 8'h03;
    rom4[3] = 8'hA0; rom4[4] = 8'h90; rom4[5] = 8'hB6;
    sw4 = 4'b1010;
    reset4_pulse();
    tick();
    chk("in_b", {12'd0, u4.b_q}, 16'hA);
    tick();
    tick();
    chk("add_a3", {12'd0, u4.a_q}, 16'hD);
    chk("led_unchanged", {12'd0, led4}, 16'h0);
    tick();
    chk("out_a", {12'd0, led4}, 16'hD);
    tick();
    chk("out_b", {12'd0, led4}, 16'hA);
    tick();
    chk("out_im", {12'd0, led4}, 16'h6);

    // HALT at PC=2, hold while step_en toggles, then reset resumes
    fill4(8'hC0);
    rom4[0] = 8'hB5; rom4[1] = 8'h33; rom4[2] = 8'h80; rom4[3] = 8'h39;
    reset4_pulse();
    tick();
    tick();
    tick();
    chk("halt_flag", {15'd0, halted4}, 16'h1);
    for (int i = 0; i < 4; i++) begin
      step4 = ~step4;
      tick();
    end
    chk("halt_pc_hold", {12'd0, addr4}, 16'h2);
    chk("halt_led_hold", {12'd0, led4}, 16'h5);
    chk("halt_a_hold", {12'd0, u4.a_q}, 16'h3);
    step4 = 1'b1;
    reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
    chk("halt_rst_flag", {15'd0, halted4}, 16'h0);
    chk("halt_rst_pc", {12'd0, addr4}, 16'h0);
    chk("halt_rst_led", {12'd0, led4}, 16'h0);
    tick();
    chk("resume_led", {12'd0, led4}, 16'h5);
    chk("resume_pc", {12'd0, addr4}, 16'h1);

    // 8-bit instance with RESET_PC = 8'h10
    rom8[8'h10] = 12'h3F0; rom8[8'h11] = 12'h020; rom8[8'h12] = 12'hFFF;
    reset8 = 1'b1;
    tick();
    reset8 = 1'b0;
    chk("w8_reset_pc", {8'd0, addr8}, 16'h0010);
    step8 = 1'b1;
    tick();
    tick();
    chk("w8_add_a", {8'd0, u8.a_q}, 16'h0010);
    chk("w8_add_carry", {15'd0, carry8}, 16'h1);
    tick();
    chk("w8_jmp", {8'd0, addr8}, 16'h00FF);
    tick();
    chk("w8_pc_wrap", {8'd0, addr8}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
